// File: rtl/tick_scheduler.sv
// tick_scheduler: multi-channel timer scheduler sharing one decrementer.
// After each prescaler tick the channels are swept one per clock; each
// channel whose count expires emits a one-cycle ch_tick pulse.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   tick_in          one-cycle prescaler pulse that starts a sweep
//   cfg_we/cfg_ch    configuration write strobe and channel address
//   cfg_period       period in ticks for the addressed channel
//   cfg_mode         0 = one-shot, 1 = periodic
//   start/stop       per-channel arm / disarm pulses (stop wins)
//   overrun_clr      clears the sticky overrun flag
//   ch_tick          registered one-cycle event pulse per channel
//   busy             channel armed
//   sweeping         sweep in progress
//   overrun          sticky: tick_in arrived while sweeping
module tick_scheduler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 8,
    localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_in,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_mode,
    input  logic [NUM_CH-1:0]   start,
    input  logic [NUM_CH-1:0]   stop,
    input  logic                overrun_clr,
    output logic [NUM_CH-1:0]   ch_tick,
    output logic [NUM_CH-1:0]   busy,
    output logic                sweeping,
    output logic                overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                sweeping_d;
    logic                overrun_d;
    logic [NUM_CH-1:0]   ch_tick_d;

    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] period_d [NUM_CH];
    logic [PERIOD_W-1:0] count_q  [NUM_CH];
    logic [PERIOD_W-1:0] count_d  [NUM_CH];
    logic [NUM_CH-1:0]   mode_q, mode_d;
    logic [NUM_CH-1:0]   active_q, active_d;
    logic                svc;

    assign busy = active_q;

    // Next-state, channel update and registered-output computation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sweeping_d = 1'b0;
        overrun_d  = overrun;
        ch_tick_d  = '0;
        period_d   = period_q;
        count_d    = count_q;
        mode_d     = mode_q;
        active_d   = active_q;
        svc        = (state_q == SWEEP);

        case (state_q)
            IDLE: begin
                if (tick_in) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        sweeping_d = (state_d == SWEEP);

        // A tick during a sweep is dropped; setting beats clearing
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (svc && tick_in) begin
            overrun_d = 1'b1;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            // Out-of-range cfg_ch matches no channel, so the write is dropped
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                period_d[i] = cfg_period;
                mode_d[i]   = cfg_mode;
            end

            // Shared decrementer services only the channel at idx
            if (svc && (idx_q == CH_W'(i)) && active_q[i]) begin
                if (count_q[i] == PERIOD_W'(1)) begin
                    ch_tick_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        count_d[i] = period_q[i];
                    end else begin
                        active_d[i] = 1'b0;
                    end
                end else if (count_q[i] > PERIOD_W'(1)) begin
                    count_d[i] = count_q[i] - PERIOD_W'(1);
                end
            end

            // Client start/stop override any sweep update of this cycle
            if (start[i] && (period_q[i] != '0)) begin
                count_d[i]   = period_q[i];
                active_d[i]  = 1'b1;
                ch_tick_d[i] = 1'b0;
            end
            if (stop[i]) begin
                active_d[i]  = 1'b0;
                ch_tick_d[i] = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sweeping <= 1'b0;
            overrun  <= 1'b0;
            ch_tick  <= '0;
            mode_q   <= '0;
            active_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sweeping <= sweeping_d;
            overrun  <= overrun_d;
            ch_tick  <= ch_tick_d;
            mode_q   <= mode_d;
            active_q <= active_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel timer scheduler driven by the shared slow prescaler tick. Debouncers, LED blinkers and timeouts each get a channel with a programmable period and mode. The scheduler services all channels with one time-shared decrementer, sweeping them one per clock after each tick. It emits one-cycle per-channel event pulses, so clients do not each carry a wide counter.

## Interface
- NUM_CH, 4, number of channels (2..16)
- PERIOD_W, 8, period/count width in prescaler ticks
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden)

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tick_in  in  1  one-cycle prescaler pulse (shared prescaler output)
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel addressed by cfg_we
- cfg_period  in  PERIOD_W  period in ticks for cfg_ch
- cfg_mode  in  1  0 = one-shot, 1 = periodic
- start  in  NUM_CH  per-channel arm pulse
- stop  in  NUM_CH  per-channel disarm pulse
- overrun_clr  in  1  clears overrun
- ch_tick  out  NUM_CH  one-cycle event pulse per channel, registered
- busy  out  NUM_CH  channel armed (active)
- sweeping  out  1  sweep in progress
- overrun  out  1  sticky: tick_in arrived while sweeping

## Operation
- Per-channel state: period[i], mode[i], count[i], active[i]. Reset clears all of it to 0.
- Config writes: accepted every cycle. They update period/mode only; a running count is not touched, and the new period takes effect at the next start or reload. cfg_ch >= NUM_CH: write ignored.
- start[i]: count[i] <= period[i], active[i] <= 1. This restarts an already-active channel.
  - If period[i] == 0, start is ignored and the channel stays inactive.
- stop[i]: active[i] <= 0. start[i] and stop[i] in the same cycle: stop wins.
- FSM, two states: IDLE, SWEEP. Index register idx (CH_W bits).
  - IDLE: tick_in=1 -> SWEEP, idx <= 0.
  - SWEEP: service channel idx. At idx == NUM_CH-1 -> IDLE, otherwise idx <= idx+1.
- Service of channel i when active[i] = 1:
  - count == 1: assert ch_tick[i] next cycle. Periodic: count <= period[i]. One-shot: active[i] <= 0.
  - count > 1: count <= count-1.
  - Inactive channel: no change.
- Priority on the serviced channel: a start/stop in the same cycle overrides the sweep update. The start reloads, the stop disarms, and no ch_tick is produced for that service.
- Overrun: tick_in=1 while in SWEEP sets overrun and that tick is dropped. This includes the final sweep cycle. overrun_clr clears it; a set in the same cycle as a clear wins.
- Reset, including mid-sweep: FSM <= IDLE, idx <= 0, all outputs 0, all channel state cleared. Any pending ch_tick is lost.

## Timing
- Reset values: ch_tick=0, busy=0, sweeping=0, overrun=0.
- tick_in high at cycle T:
  - sweeping is high for cycles T+1 .. T+NUM_CH.
  - Channel i is serviced at T+1+i.
  - ch_tick[i] is high only at cycle T+2+i.
- Minimum tick_in spacing is NUM_CH+1 cycles; closer spacing produces overrun.
- busy[i] rises the cycle after start. On a one-shot expiry, busy falls in the same cycle that ch_tick rises.
- Period P (P >= 1): the first ch_tick comes on the P-th accepted tick after start; periodic channels then fire every P ticks.
- ch_tick pulses for different channels never coincide; at most one bit is high per cycle.

## Test plan
- Periodic: ch0 period=3, mode=1, start[0]. Ticks at T=10,20,30,40,50,60 -> ch_tick[0] high only at cycles 32 and 62; busy[0] stays 1.
- One-shot: ch1 period=2, mode=0, start[1]. Ticks at T=10,20,30 -> ch_tick[1] only at cycle 23; busy[1] falls at 23; no pulse after the third tick.
- Overrun (NUM_CH=4): ticks at T=10 and 12 -> overrun=1 from cycle 13; the second tick is dropped (counts drop by one only). overrun_clr at 20 -> overrun=0 at 21.
- Collisions: start[2] and stop[2] in the same cycle -> busy[2] stays 0. start[0] at T+1 of a sweep -> count[0] reloaded to period, no ch_tick. cfg_period=0 then start[3] -> busy[3] stays 0.
- Reconfig while running: ch0 periodic with period 4; write period=2 after the 1st tick -> next pulse on the 4th tick, then every 2 ticks.
- Reset mid-sweep: assert rst_n=0 at T+2 for one cycle -> sweeping, busy, ch_tick all 0 next cycle; the next tick produces no pulse until channels are re-armed.
